// File: rtl/uart_tx.sv
// Serial UART transmitter: start, 8 data bits LSB first, parity, one stop bit.
// A one-entry holding register is double-buffered against the shift register.
module uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic       mclkx16,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] data,
    output logic       tx,
    output logic       txrdy,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_tick;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [7:0]      r_hold;
    logic            r_txrdy;
    logic            r_tx;
    logic            r_busy;

    state_t          w_state_next;
    logic [CW-1:0]   w_tick_next;
    logic [2:0]      w_bitcnt_next;
    logic [7:0]      w_shift_next;
    logic            w_parity_next;
    logic [7:0]      w_hold_next;
    logic            w_txrdy_next;
    logic            w_tx_next;
    logic            w_busy_next;
    logic            w_tick_last;
    logic            w_transfer;

    assign w_tick_last = (r_tick == TICK_LAST);
    // Holding full is required for a transfer, so a write can never coincide with one.
    assign w_transfer  = !r_txrdy && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick_last));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_next  = r_state;
        w_tick_next   = r_tick;
        w_bitcnt_next = r_bitcnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_hold_next   = r_hold;
        w_txrdy_next  = r_txrdy;
        w_tx_next     = 1'b1;
        w_busy_next   = 1'b1;

        if (r_state != S_IDLE) begin
            w_tick_next = w_tick_last ? '0 : r_tick + CW'(1);
        end

        case (r_state)
            S_START: begin
                if (w_tick_last) begin
                    w_state_next  = S_DATA;
                    w_bitcnt_next = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tick_last) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_bitcnt_next = r_bitcnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick_last) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase

        if (w_transfer) begin
            w_state_next  = S_START;
            w_tick_next   = '0;
            w_bitcnt_next = 3'd0;
            w_shift_next  = r_hold;
            w_parity_next = PARITY_ODD ? ~(^r_hold) : ^r_hold;
            w_txrdy_next  = 1'b1;
        end else if (write && r_txrdy) begin
            w_hold_next  = data;
            w_txrdy_next = 1'b0;
        end

        // The line is registered, so it is decoded from the state being entered.
        case (w_state_next)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
            end
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_parity_next;
            S_STOP:   w_tx_next = 1'b1;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge mclkx16) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_hold   <= 8'd0;
            r_txrdy  <= 1'b1;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tick   <= w_tick_next;
            r_bitcnt <= w_bitcnt_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_hold   <= w_hold_next;
            r_txrdy  <= w_txrdy_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end

    assign tx    = r_tx;
    assign txrdy = r_txrdy;
    assign busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus a line decoder.
module tb_uart_tx;

    localparam int OS    = 16;
    localparam int FRAME = 11 * OS;

    logic       mclkx16 = 1'b0;
    logic       reset;
    logic       write;
    logic [7:0] data;
    logic       tx;
    logic       txrdy;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] stream_bytes [8];
    logic       obs_parity   [8];

    uart_tx #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut (
        .mclkx16 (mclkx16),
        .reset   (reset),
        .write   (write),
        .data    (data),
        .tx      (tx),
        .txrdy   (txrdy),
        .busy    (busy)
    );

    always #5 mclkx16 = ~mclkx16;

    // Expected line level for bit slot idx (0 start, 1..8 data, 9 parity, 10 stop).
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        int ones;
        ones = $countones(b);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    task automatic step;
        @(posedge mclkx16);
        #1;
    endtask

    // Sends n bytes from stream_bytes back to back, each written the cycle its
    // predecessor is transferred, and checks every line cycle against the model.
    task automatic send_stream(input int n);
        int   next;
        int   f;
        int   w;
        logic e_tx;
        logic e_rdy;
        logic bad;
        logic g_tx, g_busy, g_rdy, x_tx, x_rdy;
        bad = 1'b0;
        g_tx = 1'b0; g_busy = 1'b0; g_rdy = 1'b0; x_tx = 1'b0; x_rdy = 1'b0;
        write = 1'b1;
        data  = stream_bytes[0];
        step;
        write = 1'b0;
        data  = 8'($urandom);
        checks++;
        if (txrdy !== 1'b0) begin
            failures++;
            $display("FAIL accept_txrdy: got %b expected 0", txrdy);
        end
        next = 1;
        step;
        for (int c = 0; c < n * FRAME; c++) begin
            if (c > 0) begin
                step;
                write = 1'b0;
                data  = 8'($urandom);
            end
            f     = c / FRAME;
            w     = (c % FRAME) / OS;
            e_tx  = exp_bit(stream_bytes[f], w);
            e_rdy = ((c % FRAME) == 0) || (f == n - 1);
            if (!bad && (tx !== e_tx || busy !== 1'b1 || txrdy !== e_rdy)) begin
                bad = 1'b1;
                g_tx = tx; g_busy = busy; g_rdy = txrdy; x_tx = e_tx; x_rdy = e_rdy;
            end
            if (w == 9 && (c % OS) == OS / 2) obs_parity[f] = tx;
            if ((c % FRAME) == 0 && next < n) begin
                write = 1'b1;
                data  = stream_bytes[next];
                next++;
            end
            if ((c % OS) == OS - 1) begin
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL frame%0d_slot%0d byte=%02h: got tx=%b busy=%b txrdy=%b expected tx=%b busy=1 txrdy=%b",
                             f, w, stream_bytes[f], g_tx, g_busy, g_rdy, x_tx, x_rdy);
                end
                bad = 1'b0;
            end
        end
        step;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || txrdy !== 1'b1) begin
            failures++;
            $display("FAIL after_stream: got tx=%b busy=%b txrdy=%b expected tx=1 busy=0 txrdy=1", tx, busy, txrdy);
        end
    endtask

    // Line decoder: finds a start bit within a cycle budget and samples mid-bit.
    task automatic recv_frame(output logic [7:0] b, output logic par, output logic stp, output logic got);
        got = 1'b0;
        b   = 8'h00;
        par = 1'b0;
        stp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step;
            if (tx === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) return;
        repeat (OS / 2) step;
        for (int i = 0; i < 8; i++) begin
            repeat (OS) step;
            b[i] = tx;
        end
        repeat (OS) step;
        par = tx;
        repeat (OS) step;
        stp = tx;
    endtask

    task automatic test_reset;
        logic bad;
        reset = 1'b1;
        write = 1'b1;
        data  = 8'hFF;
        step;
        step;
        checks++;
        if (tx !== 1'b1 || txrdy !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got tx=%b txrdy=%b busy=%b expected tx=1 txrdy=1 busy=0", tx, txrdy, busy);
        end
        reset = 1'b0;
        write = 1'b0;
        data  = 8'h00;
        bad   = 1'b0;
        repeat (20) begin
            step;
            if (tx !== 1'b1 || busy !== 1'b0 || txrdy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_after_reset: got tx=%b busy=%b txrdy=%b expected tx=1 busy=0 txrdy=1", tx, busy, txrdy);
        end
    endtask

    task automatic test_single;
        stream_bytes[0] = 8'h0F;
        send_stream(1);
    endtask

    task automatic test_parity;
        logic [7:0] pbytes [4];
        logic       pexp   [4];
        pbytes = '{8'h00, 8'hFF, 8'h01, 8'hA5};
        pexp   = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            stream_bytes[0] = pbytes[i];
            send_stream(1);
            checks++;
            if (obs_parity[0] !== pexp[i]) begin
                failures++;
                $display("FAIL parity_%02h: got %b expected %b", pbytes[i], obs_parity[0], pexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        stream_bytes[0] = 8'h55;
        stream_bytes[1] = 8'hAA;
        send_stream(2);
        for (int i = 0; i < 4; i++) stream_bytes[i] = 8'($urandom);
        send_stream(4);
    endtask

    task automatic test_write_while_full;
        fork
            begin
                write = 1'b1;
                data  = 8'h11;
                step;
                data  = 8'h22;
                step;
                step;
                data  = 8'h33;
                repeat (20) step;
                write = 1'b0;
                data  = 8'h00;
            end
            begin
                logic [7:0] b;
                logic       p, s, g, seen;
                logic [7:0] exp_b [2];
                exp_b = '{8'h11, 8'h22};
                for (int k = 0; k < 2; k++) begin
                    recv_frame(b, p, s, g);
                    checks++;
                    if (!g || b !== exp_b[k] || p !== exp_bit(exp_b[k], 9) || s !== 1'b1) begin
                        failures++;
                        $display("FAIL wwf_frame%0d: got found=%b byte=%02h par=%b stop=%b expected found=1 byte=%02h par=%b stop=1",
                                 k, g, b, p, s, exp_b[k], exp_bit(exp_b[k], 9));
                    end
                end
                seen = 1'b0;
                repeat (300) begin
                    step;
                    if (tx === 1'b0) seen = 1'b1;
                end
                checks++;
                if (seen || busy !== 1'b0 || txrdy !== 1'b1) begin
                    failures++;
                    $display("FAIL wwf_no_third: got start_seen=%b busy=%b txrdy=%b expected start_seen=0 busy=0 txrdy=1",
                             seen, busy, txrdy);
                end
            end
        join
    endtask

    task automatic test_reset_midframe;
        logic bad;
        write = 1'b1;
        data  = 8'h0F;
        step;
        write = 1'b0;
        step;
        write = 1'b1;
        data  = 8'h3C;
        step;
        write = 1'b0;
        repeat (48) step;
        checks++;
        if (txrdy !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_full: got txrdy=%b busy=%b expected txrdy=0 busy=1", txrdy, busy);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || txrdy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_reset: got tx=%b busy=%b txrdy=%b expected tx=1 busy=0 txrdy=1", tx, busy, txrdy);
        end
        bad = 1'b0;
        repeat (200) begin
            step;
            if (tx !== 1'b1 || busy !== 1'b0 || txrdy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL line_quiet_after_reset: got tx=%b busy=%b txrdy=%b expected tx=1 busy=0 txrdy=1", tx, busy, txrdy);
        end
    endtask

    task automatic test_loopback;
        fork
            begin
                logic ok;
                for (int j = 0; j < 4; j++) begin
                    ok = 1'b0;
                    for (int t = 0; t < 1000; t++) begin
                        if (txrdy === 1'b1) begin
                            ok = 1'b1;
                            break;
                        end
                        step;
                    end
                    checks++;
                    if (!ok) begin
                        failures++;
                        $display("FAIL loop_txrdy_wait%0d: got timeout expected txrdy=1", j);
                        break;
                    end
                    write = 1'b1;
                    data  = 8'h0F;
                    step;
                    write = 1'b0;
                    data  = 8'($urandom);
                    step;
                end
            end
            begin
                logic [7:0] b;
                logic       p, s, g;
                for (int k = 0; k < 4; k++) begin
                    recv_frame(b, p, s, g);
                    checks++;
                    if (!g || b !== 8'h0F || p !== exp_bit(8'h0F, 9) || s !== 1'b1) begin
                        failures++;
                        $display("FAIL loop_frame%0d: got found=%b byte=%02h par=%b stop=%b expected found=1 byte=0f par=%b stop=1",
                                 k, g, b, p, s, exp_bit(8'h0F, 9));
                    end
                end
            end
        join
        repeat (FRAME) step;
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0;
        data  = 8'h00;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_write_while_full();
        test_reset_midframe();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that produces the line driven into uart_rx.
- Clocked by the same 16x-baud clock, mclkx16.
- Accepts one byte at a time from the host through a one-entry holding register, double-buffered against a shift register.
- Serialises each byte as: start (0), 8 data bits LSB first, odd parity, 1 stop (1); each bit lasts exactly OVERSAMPLE clocks.

Parameters:
- OVERSAMPLE, 16, mclkx16 cycles per bit; must be >= 2. Counter width is clog2(OVERSAMPLE).
- PARITY_ODD, 1, 1 = odd parity (parity bit = ~^data), 0 = even parity (parity bit = ^data).

Ports:
- mclkx16  input  1  16x-baud clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  host write strobe; sampled on each rising edge.
- data  input  8  byte to send; captured when a write is accepted.
- tx  output  1  serial line, registered; idles high.
- txrdy  output  1  1 = holding register empty, write will be accepted.
- busy  output  1  1 while a frame (start through stop) is on the line.

Behaviour:
- Clock and reset: one clock, mclkx16. Reset is synchronous and active-high, named reset.
- Reset values: tx=1, txrdy=1, busy=0, holding register empty, FSM=IDLE, bit counter=0, tick counter=0, shift register=0.
- Write acceptance:
  - Accepted on an edge where write=1 and the holding register is empty; data is latched and txrdy=0 after that edge.
  - write with txrdy=0 is ignored: no data change, no side effects.
  - txrdy is exactly ~hold_full, registered.
- Transfer: when holding is full and the FSM is in IDLE, or at the final tick of STOP, the next edge:
  - loads the shift register;
  - computes parity from the loaded byte;
  - empties the holding register (txrdy=1);
  - enters START.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right once per bit; bit counter 0..7.
  - PARITY: tx=parity bit.
  - STOP: tx=1.
  - busy=1 in all states except IDLE.
- Tick counter: counts 0..OVERSAMPLE-1 in every non-IDLE state. At OVERSAMPLE-1 it wraps to 0 and the FSM advances:
  - START to DATA.
  - DATA to DATA while bit counter<7, else to PARITY.
  - PARITY to STOP.
  - STOP to START if holding is full (back-to-back, no idle gap), else to IDLE.
- Latency:
  - Write accepted at edge k with FSM idle: transfer at edge k+1, tx=0 after edge k+1, txrdy=1 after edge k+1 (low for exactly one cycle).
  - Frame length is 11*OVERSAMPLE clocks (176 at default).
- Back-to-back:
  - A second byte may be written any time txrdy=1 during a frame.
  - It starts on the cycle after the 16th stop-bit clock.
  - No third byte is accepted until that transfer.
- Simultaneous events: a write on the same edge as a transfer is impossible, because a transfer requires holding full, so txrdy=0.
- Reset mid-frame:
  - The frame is aborted; tx=1 and busy=0 after the reset edge.
  - The holding register is discarded (txrdy=1).
  - No partial bits after reset.
- Data port: only sampled on an accepted write; later changes to data do not affect the queued or in-flight byte.

Test Plan:
- Reset, then write 0x0F once:
  - tx holds each value for 16 clocks: 0, 1,1,1,1, 0,0,0,0, 1 (parity), 1 (stop);
  - total 176 clocks; busy=1 throughout; tx=1 and busy=0 afterward.
- Parity values with PARITY_ODD=1:
  - 0x00 gives parity bit 1.
  - 0xFF gives parity bit 1.
  - 0x01 gives parity bit 0.
  - 0xA5 gives parity bit 1.
- Back-to-back:
  - write 0x55, then write 0xAA as soon as txrdy returns to 1;
  - second start bit begins exactly 176 clocks after the first, with no idle high between stop and start;
  - txrdy=1 after the second transfer.
- Write while full:
  - write 0x11, 0x22, then 0x33 while txrdy=0;
  - only 0x11 and 0x22 are transmitted; 0x33 is dropped.
- Reset mid-frame:
  - assert reset at clock 50 of a 0x0F frame;
  - tx=1, busy=0, txrdy=1 on the next edge; line stays high.
- Loopback: uart_tx.tx into uart_rx.rx with read tied to ~rxrdy, sending 0x0F four times.
  - uart_rx reports rdata=0x0F with rxrdy pulsing four times.
  - parityerr=0, framingerr=0, overrun=0 throughout.
